// File: rtl/jk_cmd_sequencer.sv
// Buffers hold/reset/set/toggle commands in a small FIFO and replays each as registered J/K
// for rep+1 consecutive cycles. Define JK_SEQ_FLUSH_EN to add a synchronous flush input.
module jk_cmd_sequencer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 4,
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
`ifdef JK_SEQ_FLUSH_EN
  input  logic             flush,
`endif
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_rep,
  output logic             J,
  output logic             K,
  output logic             busy,
  output logic             done,
  output logic [LVL_W-1:0] level
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned ENT_W = CNT_W + 2;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               j_q, j_d, k_q, k_d, done_q, done_d;
  logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]   level_q, level_d;
  logic [ENT_W-1:0]   mem_q [DEPTH];

  logic               flush_w, push, pop, can_pop;
  logic [ENT_W-1:0]   head;
  logic [1:0]         head_op;
  logic [CNT_W-1:0]   head_rep;

`ifdef JK_SEQ_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  assign cmd_ready = (level_q != LVL_W'(DEPTH));
  assign busy      = (state_q == StRun) || (level_q != '0);
  assign level     = level_q;
  assign J         = j_q;
  assign K         = k_q;
  assign done      = done_q;

  assign head     = mem_q[rd_ptr_q];
  assign head_op  = head[ENT_W-1:CNT_W];
  assign head_rep = head[CNT_W-1:0];
  assign can_pop  = (level_q != '0);
  // Flush drops any push presented in the same cycle.
  assign push     = cmd_valid && cmd_ready && !flush_w;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    j_d     = j_q;
    k_d     = k_q;
    done_d  = 1'b0;
    pop     = 1'b0;
    if (flush_w) begin
      state_d = StIdle;
      cnt_d   = '0;
      j_d     = 1'b0;
      k_d     = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (can_pop) begin
            pop          = 1'b1;
            state_d      = StRun;
            {j_d, k_d}   = head_op;
            cnt_d        = head_rep;
            done_d       = (head_rep == '0);
          end
        end
        StRun: begin
          if (cnt_q != '0) begin
            cnt_d  = cnt_q - CNT_W'(1);
            done_d = (cnt_q == CNT_W'(1));
          end else if (can_pop) begin
            // Chain straight into the next command with no idle cycle.
            pop        = 1'b1;
            {j_d, k_d} = head_op;
            cnt_d      = head_rep;
            done_d     = (head_rep == '0);
          end else begin
            state_d = StIdle;
            j_d     = 1'b0;
            k_d     = 1'b0;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    level_d = level_q;
    if (flush_w) begin
      level_d = '0;
    end else begin
      unique case ({push, pop})
        2'b10:   level_d = level_q + LVL_W'(1);
        2'b01:   level_d = level_q - LVL_W'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      j_q      <= 1'b0;
      k_q      <= 1'b0;
      done_q   <= 1'b0;
      level_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      j_q     <= j_d;
      k_q     <= k_d;
      done_q  <= done_d;
      level_q <= level_d;
      if (flush_w) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      end
    end
  end

  // Storage needs no reset; occupancy is tracked by level_q.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {cmd_op, cmd_rep};
  end

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// Directed bench for jk_cmd_sequencer; the flush scenario runs when JK_SEQ_FLUSH_EN is defined.
module tb_jk_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_rep;
  logic       j, k, busy, done;
  logic [2:0] level;
`ifdef JK_SEQ_FLUSH_EN
  logic       flush;
`endif

  int n_vec = 0;
  int n_err = 0;

  jk_cmd_sequencer #(.DEPTH(4), .CNT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef JK_SEQ_FLUSH_EN
    .flush     (flush),
`endif
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_rep   (cmd_rep),
    .J         (j),
    .K         (k),
    .busy      (busy),
    .done      (done),
    .level     (level)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [3:0] rep);
    cmd_valid = v;
    cmd_op    = op;
    cmd_rep   = rep;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 2'd0, 4'd0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Expected occupancy in the full-FIFO scenario, indexed by negedge number.
  function automatic logic [2:0] full_level(input int c);
    if (c <= 2)  return 3'd1;
    if (c == 3)  return 3'd2;
    if (c == 4)  return 3'd3;
    if (c == 18) return 3'd3;
    return 3'd4;
  endfunction

  logic [1:0] t1_jk [6] = '{2'd0, 2'd0, 2'd2, 2'd2, 2'd2, 2'd0};
  logic       t1_dn [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [1:0] t2_jk [7] = '{2'd0, 2'd0, 2'd3, 2'd1, 2'd1, 2'd0, 2'd0};
  logic       t2_dn [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int   n_on, n_done, done_at;
    logic q;
    rst = 1'b0;
`ifdef JK_SEQ_FLUSH_EN
    flush = 1'b0;
`endif
    drive(1'b0, 2'd0, 4'd0);
    repeat (2) @(negedge clk);
    check_eq("rst_j", j, 0);
    check_eq("rst_k", k, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_level", level, 0);
    check_eq("rst_ready", cmd_ready, 1);
    rst = 1'b1;

    // Single set command, rep=2.
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check_eq($sformatf("single_jk_c%0d", c), {j, k}, t1_jk[c]);
      check_eq($sformatf("single_done_c%0d", c), done, t1_dn[c]);
      if (c == 0) drive(1'b1, 2'd2, 4'd2);
      if (c == 1) begin
        drive(1'b0, 2'd0, 4'd0);
        check_eq("single_level_queued", level, 1);
        check_eq("single_busy_queued", busy, 1);
      end
    end
    check_eq("single_busy_end", busy, 0);
    check_eq("single_level_end", level, 0);

    // Back-to-back commands: toggle/0, reset/1, hold/0.
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      check_eq($sformatf("b2b_jk_c%0d", c), {j, k}, t2_jk[c]);
      check_eq($sformatf("b2b_done_c%0d", c), done, t2_dn[c]);
      case (c)
        0: drive(1'b1, 2'd3, 4'd0);
        1: drive(1'b1, 2'd1, 4'd1);
        2: drive(1'b1, 2'd0, 4'd0);
        3: drive(1'b0, 2'd0, 4'd0);
        default: ;
      endcase
    end
    check_eq("b2b_busy_end", busy, 0);

    // Full FIFO with valid held high; a sixth command waits for the next pop.
    for (int c = 0; c < 21; c++) begin
      @(negedge clk);
      if (c >= 1) begin
        check_eq($sformatf("full_level_c%0d", c), level, full_level(c));
        check_eq($sformatf("full_ready_c%0d", c), cmd_ready, full_level(c) != 3'd4);
      end
      if (c >= 2) begin
        check_eq($sformatf("full_jk_c%0d", c), {j, k}, 2'd3);
        check_eq($sformatf("full_done_c%0d", c), done, c == 17);
      end
      if (c == 0)  drive(1'b1, 2'd3, 4'd15);
      if (c == 19) drive(1'b0, 2'd0, 4'd0);
    end
    do_reset();

    // Max repeat toggle: a downstream JK flop must return to its starting Q.
    n_on = 0; n_done = 0; done_at = -1; q = 1'b0;
    for (int c = 0; c < 22; c++) begin
      @(negedge clk);
      if (j && k) n_on++;
      if (done) begin
        n_done++;
        done_at = c;
      end
      q = (j && k) ? ~q : (j ? 1'b1 : (k ? 1'b0 : q));
      if (c == 0) drive(1'b1, 2'd3, 4'd15);
      if (c == 1) drive(1'b0, 2'd0, 4'd0);
    end
    check_eq("maxrep_cycles", n_on, 16);
    check_eq("maxrep_q_final", q, 0);
    check_eq("maxrep_done_count", n_done, 1);
    check_eq("maxrep_done_at", done_at, 17);
    check_eq("maxrep_busy_end", busy, 0);

    // Asynchronous reset in the second cycle of a set/5 command with one more queued.
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (c == 0) drive(1'b1, 2'd2, 4'd5);
      if (c == 1) drive(1'b1, 2'd1, 4'd0);
      if (c == 2) drive(1'b0, 2'd0, 4'd0);
    end
    check_eq("rstmid_pre_j", j, 1);
    check_eq("rstmid_pre_level", level, 1);
    #2 rst = 1'b0;
    #1;
    check_eq("rstmid_j", j, 0);
    check_eq("rstmid_k", k, 0);
    check_eq("rstmid_done", done, 0);
    check_eq("rstmid_busy", busy, 0);
    check_eq("rstmid_level", level, 0);
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_eq($sformatf("rstpost_jkd_c%0d", c), {j, k, done}, 3'd0);
      check_eq($sformatf("rstpost_level_c%0d", c), level, 0);
      check_eq($sformatf("rstpost_ready_c%0d", c), cmd_ready, 1);
    end

`ifdef JK_SEQ_FLUSH_EN
    // Flush with one command executing and three queued, plus a push that must be dropped.
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c < 4) drive(1'b1, 2'd2, 4'd7);
    end
    check_eq("flush_pre_level", level, 3);
    check_eq("flush_pre_j", j, 1);
    drive(1'b1, 2'd3, 4'd0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    drive(1'b0, 2'd0, 4'd0);
    check_eq("flush_jk", {j, k}, 2'd0);
    check_eq("flush_level", level, 0);
    check_eq("flush_busy", busy, 0);
    check_eq("flush_done", done, 0);
    @(negedge clk);
    check_eq("flush_stay_jkd", {j, k, done}, 3'd0);
    check_eq("flush_stay_level", level, 0);
    drive(1'b1, 2'd1, 4'd0);
    @(negedge clk);
    drive(1'b0, 2'd0, 4'd0);
    @(negedge clk);
    check_eq("flush_next_jk", {j, k}, 2'd1);
    check_eq("flush_next_done", done, 1);
    @(negedge clk);
    check_eq("flush_next_busy", busy, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
